// File: rtl/ps2_scancode_rx_if.sv
// ps2_scancode_rx_if
//   Decoded scan-code event bus from the PS/2 receive front end to the
//   game key-decode logic.
//   code      [7:0] scan code of the last event, held until the next one
//   ext             event was preceded by an E0 prefix
//   brk             event was preceded by an F0 prefix (key release)
//   valid           one-cycle pulse, new event on code/ext/brk
//   frame_err       one-cycle pulse, a frame was dropped
//   master: driven by the receiver; slave: consumed by the key decoder.
interface ps2_scancode_rx_if;
  logic [7:0] code;
  logic       ext;
  logic       brk;
  logic       valid;
  logic       frame_err;

  modport master (output code, ext, brk, valid, frame_err);
  modport slave  (input  code, ext, brk, valid, frame_err);
endinterface

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
//   PS/2 keyboard receive front end. Synchronises the raw PS2_CLK/PS2_DATA
//   pins into clk, deframes 11-bit device-to-host frames (start, 8 data LSB
//   first, parity, stop), folds E0/F0 prefixes into ext/brk flags and emits
//   one event per key action. A partial frame with no PS2_CLK falling edge
//   for TIMEOUT_CYCLES clocks is abandoned.
//   Ports:
//     clk       system clock
//     rstn      asynchronous active-low reset
//     PS2_CLK   raw keyboard clock pin (asynchronous)
//     PS2_DATA  raw keyboard data pin (asynchronous)
//     evt       event bus (code/ext/brk/valid/frame_err), master side
//   Build option: define PS2_PARITY_CHECK_EN to require odd parity; when
//   undefined the parity bit is shifted in and ignored.
//
//   state  | meaning
//   IDLE   | waiting for a start bit (data=0 on a falling edge)
//   DATA   | shifting in the 8 data bits, LSB first
//   PARITY | capturing the parity bit
//   STOP   | checking the stop bit, frame verdict handed to the event stage
module ps2_scancode_rx #(
  parameter int               SYNC_STAGES    = 2,
  parameter int               TMO_W          = 16,
  parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = TMO_W'(50000)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                PS2_CLK,
  input  logic                PS2_DATA,
  ps2_scancode_rx_if.master   evt
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   sdat;

  state_t                 state;
  logic [2:0]             bitcnt;
  logic [8:0]             shreg;     // [7:0] data, [8] parity once complete
  logic [TMO_W-1:0]       tmo;
  logic                   done;
  logic                   good;
  logic                   ext_pend;
  logic                   brk_pend;
  logic                   par_ok;
  logic                   tmo_hit;

  // Presetting to 1 keeps a reset release from looking like a falling edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DATA};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign sdat = dat_sync[SYNC_STAGES-1];

`ifdef PS2_PARITY_CHECK_EN
  // shreg holds data+parity while in STOP; odd parity means odd ones count.
  assign par_ok = ^shreg;
`else
  assign par_ok = 1'b1;
`endif

  // Compare against TIMEOUT_CYCLES-1 so the drop lands exactly
  // TIMEOUT_CYCLES clocks after the edge that last cleared the counter.
  assign tmo_hit = (state != IDLE) && (tmo == TIMEOUT_CYCLES - 1'b1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      bitcnt        <= '0;
      shreg         <= '0;
      tmo           <= '0;
      done          <= 1'b0;
      good          <= 1'b0;
      ext_pend      <= 1'b0;
      brk_pend      <= 1'b0;
      evt.code      <= '0;
      evt.ext       <= 1'b0;
      evt.brk       <= 1'b0;
      evt.valid     <= 1'b0;
      evt.frame_err <= 1'b0;
    end else begin
      evt.valid     <= 1'b0;
      evt.frame_err <= 1'b0;
      done          <= 1'b0;

      // Event stage: runs the cycle after the stop-bit edge was processed.
      if (done) begin
        if (!good) begin
          evt.frame_err <= 1'b1;
          ext_pend      <= 1'b0;
          brk_pend      <= 1'b0;
        end else if (shreg[7:0] == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shreg[7:0] == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          evt.code  <= shreg[7:0];
          evt.ext   <= ext_pend;
          evt.brk   <= brk_pend;
          evt.valid <= 1'b1;
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end
      end

      if (tmo_hit) begin
        // A coincident falling edge is deliberately dropped here.
        state         <= IDLE;
        tmo           <= '0;
        evt.frame_err <= 1'b1;
        ext_pend      <= 1'b0;
        brk_pend      <= 1'b0;
      end else begin
        if (fall || state == IDLE)
          tmo <= '0;
        else if (tmo != '1)
          tmo <= tmo + 1'b1;

        if (fall) begin
          case (state)
            IDLE: begin
              if (!sdat) begin
                state  <= DATA;
                bitcnt <= '0;
              end
            end
            DATA: begin
              shreg  <= {sdat, shreg[8:1]};
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == 3'd7) state <= PARITY;
            end
            PARITY: begin
              shreg <= {sdat, shreg[8:1]};
              state <= STOP;
            end
            STOP: begin
              done  <= 1'b1;
              good  <= sdat & par_ok;
              state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;
  localparam int S = 2;
  localparam int T = 300;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_REQ = 1'b1;
`else
  localparam bit PAR_REQ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  always #5 clk = ~clk;

  ps2_scancode_rx_if bus ();

  ps2_scancode_rx #(
    .SYNC_STAGES   (S),
    .TMO_W         (16),
    .TIMEOUT_CYCLES(16'(T))
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .PS2_CLK (ps2_clk),
    .PS2_DATA(ps2_data),
    .evt     (bus.master)
  );

  int n_chk = 0;
  int n_fail = 0;

  // pulse monitor
  int vcnt = 0;
  int ecnt = 0;
  int both = 0;
  always @(negedge clk) begin
    if (bus.valid) vcnt++;
    if (bus.frame_err) ecnt++;
    if (bus.valid && bus.frame_err) both++;
  end

  // frame-level reference model
  logic [7:0] m_code = '0;
  logic       m_ext = 1'b0, m_brk = 1'b0;
  logic       m_extp = 1'b0, m_brkp = 1'b0;
  int         m_vcnt = 0, m_ecnt = 0;
  int         lat;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_frame(logic [7:0] b, logic par, logic stop);
    logic ok;
    ok = stop && (!PAR_REQ || (^{b, par}) == 1'b1);
    if (!ok) begin
      m_ecnt++;
      m_extp = 1'b0;
      m_brkp = 1'b0;
    end else if (b == 8'hE0) begin
      m_extp = 1'b1;
    end else if (b == 8'hF0) begin
      m_brkp = 1'b1;
    end else begin
      m_code = b;
      m_ext  = m_extp;
      m_brk  = m_brkp;
      m_vcnt++;
      m_extp = 1'b0;
      m_brkp = 1'b0;
    end
  endtask

  task automatic check_state(string tag);
    check({tag, ".valid_cnt"}, vcnt, m_vcnt);
    check({tag, ".err_cnt"}, ecnt, m_ecnt);
    check({tag, ".code"}, {24'd0, bus.code}, {24'd0, m_code});
    check({tag, ".ext"}, {31'd0, bus.ext}, {31'd0, m_ext});
    check({tag, ".brk"}, {31'd0, bus.brk}, {31'd0, m_brk});
  endtask

  // one PS/2 bit; with measure set, lat records the negedge (counted from the
  // raw falling edge) on which the first valid/frame_err pulse is seen
  task automatic send_bit(logic b, bit measure);
    ps2_data = b;
    wait_n(5);
    ps2_clk = 1'b0;
    if (measure) begin
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
        @(negedge clk);
        if (lat == 0 && (bus.valid || bus.frame_err)) lat = i;
      end
    end else begin
      wait_n(12);
    end
    ps2_clk = 1'b1;
    wait_n(5);
  endtask

  task automatic send_frame(string tag, logic [7:0] b, logic par, logic stop);
    int pv, pe;
    pv = m_vcnt;
    pe = m_ecnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit(par, 1'b0);
    send_bit(stop, 1'b1);
    ps2_data = 1'b1;
    wait_n(6);
    model_frame(b, par, stop);
    check_state(tag);
    check({tag, ".latency"}, lat, (m_vcnt != pv || m_ecnt != pe) ? S + 2 : 0);
  endtask

  function automatic logic odd_par(logic [7:0] b);
    return ~(^b);
  endfunction

  initial begin
    int k;
    logic [7:0] b;
    logic p, st;

    wait_n(3);
    check("reset.code", {24'd0, bus.code}, 32'd0);
    check("reset.ext", {31'd0, bus.ext}, 32'd0);
    check("reset.brk", {31'd0, bus.brk}, 32'd0);
    check("reset.valid", {31'd0, bus.valid}, 32'd0);
    check("reset.frame_err", {31'd0, bus.frame_err}, 32'd0);
    rstn = 1'b1;
    wait_n(5);

    // directed sequences
    send_frame("make_1c", 8'h1C, 1'b0, 1'b1);
    send_frame("brk_f0", 8'hF0, odd_par(8'hF0), 1'b1);
    send_frame("brk_1c", 8'h1C, 1'b0, 1'b1);
    send_frame("after_brk_1c", 8'h1C, 1'b0, 1'b1);
    send_frame("ext_e0", 8'hE0, odd_par(8'hE0), 1'b1);
    send_frame("ext_f0", 8'hF0, odd_par(8'hF0), 1'b1);
    send_frame("ext_brk_6b", 8'h6B, odd_par(8'h6B), 1'b1);
    send_frame("plain_75", 8'h75, odd_par(8'h75), 1'b1);
    send_frame("bad_parity", 8'h1C, 1'b1, 1'b1);
    send_frame("bad_stop", 8'h1C, 1'b0, 1'b0);
    send_frame("after_stop_1d", 8'h1D, odd_par(8'h1D), 1'b1);
    send_frame("dup_e0a", 8'hE0, odd_par(8'hE0), 1'b1);
    send_frame("dup_e0b", 8'hE0, odd_par(8'hE0), 1'b1);
    send_frame("dup_e0_74", 8'h74, odd_par(8'h74), 1'b1);

    // timeout: pending break, then a frame stalled after 4 data bits
    send_frame("tmo_f0", 8'hF0, odd_par(8'hF0), 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    wait_n(5);
    ps2_clk = 1'b0;
    k = 0;
    for (int i = 1; i <= T + S + 40; i++) begin
      @(negedge clk);
      if (i == 12) ps2_clk = 1'b1;
      if (k == 0 && bus.frame_err) k = i;
    end
    check("timeout.latency", k, S + 1 + T);
    m_ecnt++;
    m_extp = 1'b0;
    m_brkp = 1'b0;
    check_state("timeout");
    send_frame("after_tmo_1c", 8'h1C, 1'b0, 1'b1);

    // reset in the middle of a frame
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    check("midrst.code", {24'd0, bus.code}, 32'd0);
    check("midrst.valid", {31'd0, bus.valid}, 32'd0);
    check("midrst.frame_err", {31'd0, bus.frame_err}, 32'd0);
    m_code = '0; m_ext = 1'b0; m_brk = 1'b0; m_extp = 1'b0; m_brkp = 1'b0;
    wait_n(4);
    rstn = 1'b1;
    wait_n(5);
    check_state("midrst");
    send_frame("after_rst_1c", 8'h1C, 1'b0, 1'b1);

    // randomized frames against the model
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      if (k < 2) b = 8'hE0;
      else if (k < 4) b = 8'hF0;
      else b = 8'($urandom);
      p = odd_par(b);
      if ($urandom_range(0, 7) == 0) p = ~p;
      st = ($urandom_range(0, 9) != 0);
      send_frame("rand", b, p, st);
    end

    check("valid_with_err", both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
- PS/2 keyboard receive front end of the Tetris top level.
- Samples the raw PS2_CLK/PS2_DATA pins in the system clock domain and deframes 11-bit device-to-host frames.
- Folds E0 (extended) and F0 (break) prefixes into flags and emits one decoded scan-code event per key action.
- Consumed directly by the game key-decode/control logic.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on PS2_CLK and PS2_DATA (minimum 2).
- TIMEOUT_CYCLES, 16'd50000, clk cycles without a PS2_CLK falling edge before a partial frame is abandoned.
- TMO_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- PS2_CLK  in  1  raw keyboard clock pin, asynchronous.
- PS2_DATA  in  1  raw keyboard data pin, asynchronous.
- code  out  8  scan code of the last event; held until the next event.
- ext  out  1  event was preceded by E0; valid with code.
- brk  out  1  event was preceded by F0 (key release); valid with code.
- valid  out  1  one-cycle pulse, new event on code/ext/brk.
- frame_err  out  1  one-cycle pulse, frame dropped (framing, parity or timeout).

Behaviour:
- Reset: asynchronous, active-low, all outputs 0. State IDLE, synchronisers preset to 1 (idle bus level), prefix flags 0, counters 0.
- Sampling:
  - PS2_CLK and PS2_DATA each pass through SYNC_STAGES flops.
  - A falling edge is synced clk previous=1, current=0.
  - Data is sampled as the synced PS2_DATA in the edge cycle.
- FSM, advancing only on falling edges:
  - IDLE: data=0 goes to DATA with bitcnt=0. data=1 is ignored and the FSM stays in IDLE.
  - DATA: shift in LSB first, bitcnt++. After the 8th bit go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: the frame is good if data=1 and the parity check passes. Always returns to IDLE.
- Good frame, registered in the cycle after the stop-bit edge cycle:
  - 0xE0: set ext_pend. No valid.
  - 0xF0: set brk_pend. No valid.
  - Any other byte: code=byte, ext=ext_pend, brk=brk_pend, valid=1 for one cycle. Then clear both pend flags.
- Bad frame: frame_err=1 for one cycle. No valid. Pend flags cleared.
- Latency: valid asserts SYNC_STAGES+2 clk cycles after the raw PS2_CLK falling edge of the stop bit.
- Timeout:
  - Counter clears on every falling edge and while in IDLE.
  - Outside IDLE it increments and saturates.
  - When it reaches TIMEOUT_CYCLES: return to IDLE, pulse frame_err, clear pend flags, discard the partial byte.
  - An edge arriving in the same cycle as the timeout: the timeout wins, and the edge is reinterpreted as a start bit by IDLE on a later edge only.
- valid and frame_err are never high in the same cycle.
- code/ext/brk change only when valid pulses.
- Extra prefixes (E0 E0, F0 F0) are idempotent. The flags simply remain set.
- Reset asserted mid-frame aborts immediately with no pulse. The next start bit after release begins a fresh frame.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: odd parity is required. The 8 data bits plus the parity bit must have an odd count of ones; a mismatch produces frame_err and drops the byte.
- Undefined: the parity bit is shifted in and ignored. Only start=0 and stop=1 are checked.

Test Plan:
- Frame start0, data 0x1C LSB-first (0,0,1,1,1,0,0,0), parity 0, stop1 -> one valid, code=0x1C, ext=0, brk=0, frame_err=0, latency SYNC_STAGES+2 from the stop edge.
- Frames F0 then 1C -> no valid after F0; single valid with code=0x1C, brk=1, ext=0. A following 1C frame gives brk=0.
- Frames E0, F0, 6B -> exactly one valid, code=0x6B, ext=1, brk=1. Flags are 0 on the next event.
- 0x1C with parity bit 1 -> with PS2_PARITY_CHECK_EN: frame_err pulse, no valid, code unchanged. Without the macro: valid, code=0x1C.
- 0x1C with stop bit 0 -> frame_err pulse, no valid. An immediately following good 0x1D frame gives valid, code=0x1D.
- Start plus 4 data bits, then PS2_CLK held high for TIMEOUT_CYCLES -> frame_err pulse at exactly TIMEOUT_CYCLES after the last synced edge. The next full 0x1C frame decodes correctly.
- Reset pulse mid-frame -> outputs 0 immediately, no pulses. A next good frame decodes correctly.
